cpu_commit_rob: RTL
===================

Name: cpu_commit_rob

Overview:
- Reorder buffer and in-order commit initiator; it produces the commit_* stream consumed by the GPR/FPR register-file write port.
- Instructions are allocated at dispatch, completed out of order by writeback, and retired strictly in program order, one per cycle.
- A head-of-buffer exception flushes all entries and redirects fetch.

Parameters:
DATA, 32, data width of writeback/commit data
ADDR, 32, PC width
DEPTH, 8, ROB entries; must be a power of 2, minimum 2
TAG, $clog2(DEPTH), entry tag width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
dispatch_e_  input  1  active-low allocate request
dispatch_rd_type  input  2  destination type: 0 NONE, 1 GPR, 2 FPR
dispatch_rd_addr  input  5  destination register address
dispatch_pc  input  ADDR  instruction PC
dispatch_jump_  input  1  active-low: link instruction; regfile writes pc+4
dispatch_tag  output  TAG  tag allocated to the current request (= tail index)
rob_full  output  1  no free entry; dispatch is ignored
rob_empty  output  1  no valid entry
wb_e_  input  1  active-low writeback strobe
wb_tag  input  TAG  entry being completed
wb_data  input  DATA  result value
wb_exp_  input  1  active-low: instruction raised an exception
commit_e_  output  1  active-low commit strobe, one cycle per retired instruction
commit_jump_  output  1  copy of the entry's dispatch_jump_
commit_rd_type  output  2  entry destination type
commit_rd_addr  output  5  entry destination address
commit_data  output  DATA  entry result
commit_pc  output  ADDR  entry PC
flush_  output  1  active-low, one-cycle pipeline flush
flush_pc  output  ADDR  PC of the excepting instruction (valid when flush_ is low)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on reset.
- Reset values: head=tail=0 with wrap bits 0; all valid/done/exp bits 0; commit_e_=1, commit_jump_=1; commit_rd_type, commit_rd_addr, commit_data, commit_pc = 0; flush_=1, flush_pc=0; rob_full=0, rob_empty=1; dispatch_tag=0.
- Pointers: head and tail are TAG+1 bits (extra wrap bit). count = tail - head, modulo 2^(TAG+1).
  - rob_full = (count == DEPTH); rob_empty = (count == 0). Both are combinational from the registers.
  - Indices wrap naturally from DEPTH-1 to 0.
- Dispatch:
  - Accepted when dispatch_e_=0, rob_full=0, and no flush is issued in that cycle.
  - On acceptance: entry[tail] gets valid=1, done=0, exp=0 plus type, addr, pc and jump_. tail increments.
  - dispatch_tag = tail[TAG-1:0], combinational.
  - Dispatch while full is dropped with no state change. Full is evaluated before any same-cycle commit, so there is no bypass.
- Writeback:
  - When wb_e_=0 and entry[wb_tag].valid=1: done=1, data=wb_data, exp=~wb_exp_.
  - Writeback to an invalid entry is ignored. A second writeback to a done entry overwrites it.
- Retire decision (combinational, on registered state): head entry valid and done.
  - exp=0: at the next edge the commit_* registers load the entry fields, commit_e_=0, valid is cleared and head increments.
  - exp=1: at the next edge flush_=0 and flush_pc=entry pc; commit_e_ stays 1; every valid bit is cleared; head=tail=0.
  - Otherwise commit_e_ and flush_ return to 1. The commit_* data registers hold their last values.
- Latency:
  - Writeback on the edge ending cycle N to the head entry gives commit_e_=0 during cycle N+2.
  - Back-to-back done entries retire on consecutive cycles, one per cycle.
- Entries with rd_type NONE still commit (commit_e_=0); the register file ignores the write.
- Simultaneous events:
  - Dispatch and retire in the same cycle are both performed, so count is unchanged.
  - Writeback and retire of the same entry in the same cycle are impossible, because retire requires done already set.
  - A writeback in a flush cycle is discarded.
  - Dispatch in a flush cycle is discarded even when rob_full=0.
- Reset mid-operation: all state returns immediately to the reset values. In-flight entries are lost and no commit or flush is emitted.

Test Plan:
- Reset, then dispatch 3 GPR ops (pc 0x100/0x104/0x108, rd 1/2/3); writeback tags 2,1,0 with data 0xC,0xB,0xA -> commit_e_ low on 3 consecutive cycles, in order, with (rd1,0xA,0x100), (rd2,0xB,0x104), (rd3,0xC,0x108); head writeback to commit latency is 2 cycles.
- Dispatch 8 ops with DEPTH=8 -> rob_full=1; a 9th dispatch is ignored and tail is unchanged. Retire one and dispatch one -> dispatch_tag=0 (wrap); rob_full is asserted again.
- Dispatch a link op with dispatch_jump_=0 at pc 0x200 -> commit_jump_=0 and commit_pc=0x200 on its commit cycle.
- Dispatch 4 ops and writeback tag 1 with wb_exp_=0 after tag 0 completes -> tag 0 commits, then flush_=0 for exactly 1 cycle with flush_pc equal to entry 1's pc. After that rob_empty=1, and the next dispatch_tag=0 and commits resume normally.
- Writeback to an unallocated tag -> no state change and no commit. Dispatch and commit in the same cycle while count=3 -> count stays 3.
- Assert reset mid-stream with 5 entries pending -> commit_e_=1, flush_=1 and rob_empty=1 immediately (asynchronous), and no commit after release.

Source files
------------

// File: rtl/cpu_commit_rob.sv
// Reorder buffer: dispatch allocates at tail, writeback completes out of order, and one entry retires per cycle in order.
// Commit/flush are registered 1 cycle after head is done; dispatch is dropped while full or during a flush.
module cpu_commit_rob #(
  parameter int DATA  = 32,
  parameter int ADDR  = 32,
  parameter int DEPTH = 8,
  parameter int TAG   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dispatch_e_,
  input  logic [1:0]      dispatch_rd_type,
  input  logic [4:0]      dispatch_rd_addr,
  input  logic [ADDR-1:0] dispatch_pc,
  input  logic            dispatch_jump_,
  output logic [TAG-1:0]  dispatch_tag,
  output logic            rob_full,
  output logic            rob_empty,
  input  logic            wb_e_,
  input  logic [TAG-1:0]  wb_tag,
  input  logic [DATA-1:0] wb_data,
  input  logic            wb_exp_,
  output logic            commit_e_,
  output logic            commit_jump_,
  output logic [1:0]      commit_rd_type,
  output logic [4:0]      commit_rd_addr,
  output logic [DATA-1:0] commit_data,
  output logic [ADDR-1:0] commit_pc,
  output logic            flush_,
  output logic [ADDR-1:0] flush_pc
);

  typedef struct packed {
    logic            jump_;
    logic [1:0]      rd_type;
    logic [4:0]      rd_addr;
    logic [ADDR-1:0] pc;
  } hdr_t;

  logic [TAG:0]      r_head, r_tail;
  logic [DEPTH-1:0]  r_vld, r_done, r_exp;
  hdr_t              r_hdr  [DEPTH];
  logic [DATA-1:0]   r_data [DEPTH];

  logic [TAG:0]      w_count;
  logic [TAG-1:0]    w_head_idx, w_tail_idx;
  logic              w_head_rdy, w_retire, w_flush, w_disp, w_wb;
  hdr_t              w_head;

  assign w_count      = r_tail - r_head;
  assign rob_full     = (w_count == (TAG+1)'(DEPTH));
  assign rob_empty    = (w_count == '0);
  assign w_head_idx   = r_head[TAG-1:0];
  assign w_tail_idx   = r_tail[TAG-1:0];
  assign dispatch_tag = w_tail_idx;
  assign w_head       = r_hdr[w_head_idx];

  // Flush takes priority: it squashes any same-cycle dispatch and writeback.
  assign w_head_rdy = r_vld[w_head_idx] & r_done[w_head_idx];
  assign w_retire   = w_head_rdy & ~r_exp[w_head_idx];
  assign w_flush    = w_head_rdy &  r_exp[w_head_idx];
  assign w_disp     = ~dispatch_e_ & ~rob_full & ~w_flush;
  assign w_wb       = ~wb_e_ & r_vld[wb_tag] & ~w_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_vld          <= '0;
      r_done         <= '0;
      r_exp          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_hdr[i]  <= '0;
        r_data[i] <= '0;
      end
      commit_e_      <= 1'b1;
      commit_jump_   <= 1'b1;
      commit_rd_type <= '0;
      commit_rd_addr <= '0;
      commit_data    <= '0;
      commit_pc      <= '0;
      flush_         <= 1'b1;
      flush_pc       <= '0;
    end else begin
      commit_e_ <= ~w_retire;
      flush_    <= ~w_flush;
      if (w_retire) begin
        commit_jump_   <= w_head.jump_;
        commit_rd_type <= w_head.rd_type;
        commit_rd_addr <= w_head.rd_addr;
        commit_data    <= r_data[w_head_idx];
        commit_pc      <= w_head.pc;
      end
      if (w_flush) begin
        flush_pc <= w_head.pc;
        r_head   <= '0;
        r_tail   <= '0;
        r_vld    <= '0;
      end else begin
        // Retire slot and dispatch slot never coincide: that needs empty or full.
        if (w_retire) begin
          r_vld[w_head_idx] <= 1'b0;
          r_head            <= r_head + (TAG+1)'(1);
        end
        if (w_disp) begin
          r_vld[w_tail_idx]  <= 1'b1;
          r_done[w_tail_idx] <= 1'b0;
          r_exp[w_tail_idx]  <= 1'b0;
          r_hdr[w_tail_idx]  <= '{jump_: dispatch_jump_, rd_type: dispatch_rd_type,
                                  rd_addr: dispatch_rd_addr, pc: dispatch_pc};
          r_tail             <= r_tail + (TAG+1)'(1);
        end
        if (w_wb) begin
          r_done[wb_tag] <= 1'b1;
          r_data[wb_tag] <= wb_data;
          r_exp[wb_tag]  <= ~wb_exp_;
        end
      end
    end
  end

endmodule
